// File: rtl/bus_if.sv
// Bus-master end of the shared bus: one arbitrated single-word access per pipeline request.
// Latency: busAs_ asserts 2 cycles after as_ with immediate grant; busy drops in the busRdy_=0 cycle.
// Backpressure: busy stalls the pipeline while requesting/accessing; stall holds completion in STALL.

`ifndef WORD_ADDR_BUS
`define WORD_ADDR_BUS 30
`endif
`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 32
`endif

module bus_if (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       busy,
    input  logic [`WORD_ADDR_BUS-1:0]  addr,
    input  logic                       as_,
    input  logic                       rw,
    input  logic [`WORD_DATA_BUS-1:0]  wrData,
    output logic [`WORD_DATA_BUS-1:0]  rdData,
    output logic                       busReq_,
    input  logic                       busGrnt_,
    output logic [`WORD_ADDR_BUS-1:0]  busAddr,
    output logic                       busAs_,
    output logic                       busRW,
    output logic [`WORD_DATA_BUS-1:0]  busWrData,
    input  logic [`WORD_DATA_BUS-1:0]  busRdData,
    input  logic                       busRdy_
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t                     state;
    logic [`WORD_DATA_BUS-1:0]  rdBuf;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= IDLE;
            rdBuf     <= '0;
            busReq_   <= 1'b1;
            busAs_    <= 1'b1;
            busRW     <= 1'b0;
            busAddr   <= '0;
            busWrData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!as_ && !flush) begin
                        busAddr   <= addr;
                        busRW     <= rw;
                        busWrData <= wrData;
                        busReq_   <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!busGrnt_) begin
                        busAs_ <= 1'b0;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe is a single-cycle pulse; grant loss or flush here never aborts.
                    busAs_ <= 1'b1;
                    if (!busRdy_) begin
                        busReq_   <= 1'b1;
                        busAddr   <= '0;
                        busRW     <= 1'b0;
                        busWrData <= '0;
                        if (busRW) begin
                            rdBuf <= busRdData;
                        end
                        state <= stall ? STALL : IDLE;
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        rdData = rdBuf;
        case (state)
            IDLE:    busy = ~as_ & ~flush;
            REQ:     busy = 1'b1;
            ACCESS: begin
                busy = busRdy_;
                // Forward slave data in the ready cycle so the pipeline need not wait for rdBuf.
                if (!busRdy_ && busRW) begin
                    rdData = busRdData;
                end
            end
            STALL:   busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bus_if.sv
// Directed and randomized transactions checked cycle by cycle against a transaction-level timeline model.
module tb_bus_if;

    logic        clk = 1'b0;
    logic        reset_;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        busReq_;
    logic        busGrnt_;
    logic [29:0] busAddr;
    logic        busAs_;
    logic        busRW;
    logic [31:0] busWrData;
    logic [31:0] busRdData;
    logic        busRdy_;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_read = 32'h0;

    bus_if dut (
        .clk       (clk),
        .reset_    (reset_),
        .stall     (stall),
        .flush     (flush),
        .busy      (busy),
        .addr      (addr),
        .as_       (as_),
        .rw        (rw),
        .wrData    (wrData),
        .rdData    (rdData),
        .busReq_   (busReq_),
        .busGrnt_  (busGrnt_),
        .busAddr   (busAddr),
        .busAs_    (busAs_),
        .busRW     (busRW),
        .busWrData (busWrData),
        .busRdData (busRdData),
        .busRdy_   (busRdy_)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ea, input logic eb,
                           input logic [29:0] ead, input logic erw, input logic [31:0] ewd,
                           input logic [31:0] erd);
        chk({tag, ".busReq_"},   {31'b0, busReq_},  {31'b0, er});
        chk({tag, ".busAs_"},    {31'b0, busAs_},   {31'b0, ea});
        chk({tag, ".busy"},      {31'b0, busy},     {31'b0, eb});
        chk({tag, ".busAddr"},   {2'b0, busAddr},   {2'b0, ead});
        chk({tag, ".busRW"},     {31'b0, busRW},    {31'b0, erw});
        chk({tag, ".busWrData"}, busWrData,         ewd);
        chk({tag, ".rdData"},    rdData,            erd);
    endtask

    // One idle cycle that must not start an access (as_ high and/or flush high).
    task automatic idle_cycle(input logic as_v, input logic fl_v);
        as_       = as_v;
        flush     = fl_v;
        stall     = 1'($urandom);
        busGrnt_  = 1'($urandom);
        busRdy_   = 1'($urandom);
        busRdData = $urandom;
        addr      = 30'($urandom);
        rw        = 1'($urandom);
        wrData    = $urandom;
        #2;
        chk_all("idle", 1'b1, 1'b1, ~as_v & ~fl_v, 30'h0, 1'b0, 32'h0, last_read);
        nxt();
        as_   = 1'b1;
        flush = 1'b0;
    endtask

    // Whole transaction: gd cycles without grant, rd not-ready ACCESS cycles,
    // sc cycles spent in STALL after completion, fl = flush held during ACCESS.
    task automatic do_access(input logic [29:0] a, input logic r, input logic [31:0] wd,
                             input int gd, input int rd, input int sc,
                             input logic [31:0] rdv, input logic fl);
        as_       = 1'b0;
        rw        = r;
        addr      = a;
        wrData    = wd;
        flush     = 1'b0;
        stall     = 1'($urandom);
        busGrnt_  = 1'($urandom);
        busRdy_   = 1'($urandom);
        busRdData = $urandom;
        #2;
        chk_all("start", 1'b1, 1'b1, 1'b1, 30'h0, 1'b0, 32'h0, last_read);
        nxt();
        as_    = 1'b1;
        rw     = 1'($urandom);
        addr   = 30'($urandom);
        wrData = $urandom;
        for (int k = 0; k <= gd; k++) begin
            busGrnt_  = (k == gd) ? 1'b0 : 1'b1;
            flush     = 1'($urandom);
            busRdy_   = 1'($urandom);
            busRdData = $urandom;
            #2;
            chk_all("req", 1'b0, 1'b1, 1'b1, a, r, wd, last_read);
            nxt();
        end
        for (int j = 0; j <= rd; j++) begin
            busRdy_   = (j == rd) ? 1'b0 : 1'b1;
            busGrnt_  = 1'($urandom);
            flush     = fl;
            stall     = (j == rd) ? (sc > 0) : 1'($urandom);
            busRdData = (j == rd) ? rdv : $urandom;
            #2;
            chk_all("acc", 1'b0, (j == 0) ? 1'b0 : 1'b1, (j == rd) ? 1'b0 : 1'b1,
                    a, r, wd, ((j == rd) && r) ? rdv : last_read);
            nxt();
        end
        if (r) last_read = rdv;
        flush    = 1'b0;
        busRdy_  = 1'b1;
        busGrnt_ = 1'b1;
        for (int s = 0; s < sc; s++) begin
            stall     = (s < sc - 1);
            as_       = 1'($urandom);
            busRdData = $urandom;
            #2;
            chk_all("stall", 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 32'h0, last_read);
            nxt();
        end
        as_   = 1'b1;
        stall = 1'b0;
    endtask

    initial begin
        reset_    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        addr      = 30'h0;
        as_       = 1'b1;
        rw        = 1'b0;
        wrData    = 32'h0;
        busGrnt_  = 1'b1;
        busRdData = 32'h0;
        busRdy_   = 1'b1;
        nxt();
        nxt();
        reset_ = 1'b1;
        #2;
        chk_all("reset", 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 32'h0, 32'h0);
        nxt();

        // Read with immediate grant and immediate ready.
        do_access(30'h0000_0010, 1'b1, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle(1'b1, 1'b0);
        // Write with 3-cycle grant delay; rdData must keep the earlier read.
        do_access(30'h0ABC_DEF0, 1'b0, 32'h1234_5678, 3, 0, 0, 32'hFFFF_0000, 1'b0);
        // Stall held at completion: 2 cycles in STALL.
        do_access(30'h0000_0123, 1'b1, 32'h0, 1, 1, 2, 32'hCAFE_F00D, 1'b0);
        // Flush blocks start in IDLE; flush during ACCESS is ignored.
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b1, 1'b0);
        do_access(30'h0000_0044, 1'b1, 32'h0, 0, 2, 0, 32'h0BAD_C0DE, 1'b1);
        // Slow slave: five not-ready cycles.
        do_access(30'h1555_5555, 1'b0, 32'hA5A5_5A5A, 0, 5, 0, 32'h0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            do_access(30'($urandom), 1'($urandom), $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), $urandom, 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                if ($urandom_range(0, 1) == 0) idle_cycle(1'b1, 1'($urandom));
                else                           idle_cycle(1'b0, 1'b1);
            end
        end

        // Reset while the slave is still not ready.
        as_      = 1'b0;
        rw       = 1'b1;
        addr     = 30'h0000_02AA;
        wrData   = 32'h0;
        busGrnt_ = 1'b0;
        busRdy_  = 1'b1;
        nxt();
        as_ = 1'b1;
        nxt();
        #2;
        chk({"pre_rst", ".busAs_"}, {31'b0, busAs_}, 32'h0);
        reset_ = 1'b0;
        nxt();
        reset_   = 1'b1;
        busGrnt_ = 1'b1;
        last_read = 32'h0;
        #2;
        chk_all("rst_mid", 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 32'h0, 32'h0);
        nxt();
        do_access(30'h0000_0777, 1'b1, 32'h0, 1, 1, 1, 32'h7777_1111, 1'b0);
        idle_cycle(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
